// File: rtl/tmr_scrub_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tmr_scrub_ctrl_pkg
//  Description : Shared types and constants for the TMR scrub controller.
//  Revision    : 1.0
// ============================================================================
package tmr_scrub_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_SCAN = 2'd2,
        ST_FIX  = 2'd3
    } scrub_state_e;

    localparam int         NUM_COPIES = 3;
    localparam logic [1:0] COPY_0     = 2'd0;
    localparam logic [1:0] COPY_1     = 2'd1;
    localparam logic [1:0] COPY_2     = 2'd2;
    localparam logic [1:0] COPY_NONE  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/tmr_scrub_ctrl_way3_voter.sv
`default_nettype none
// ============================================================================
//  Module      : way3_voter
//  Description : Bitwise 2-of-3 majority vote with single/double mismatch flags.
//  Revision    : 1.0
// ============================================================================
module way3_voter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] c_i,
    output logic [DATA_WIDTH-1:0] maj_o,
    output logic                  err1_o,
    output logic                  err2_o
);

    logic ab_eq;
    logic bc_eq;
    logic ac_eq;

    assign ab_eq  = (a_i == b_i);
    assign bc_eq  = (b_i == c_i);
    assign ac_eq  = (a_i == c_i);
    assign maj_o  = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
    assign err2_o = !ab_eq && !bc_eq && !ac_eq;
    // Any single equal pair without full agreement means exactly one copy is off.
    assign err1_o = !err2_o && !(ab_eq && bc_eq);

endmodule
`default_nettype wire

// File: rtl/tmr_scrub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tmr_scrub_ctrl
//  Description : Triplicated word store with voted read, fault injection and
//                a periodic background scrubber with error counters.
//  Revision    : 1.0
// ============================================================================
module tmr_scrub_ctrl
    import tmr_scrub_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int SCRUB_PERIOD = 1024,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       wr_en_i,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]      wr_data_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr_i,
    output logic [DATA_WIDTH-1:0]      rd_data_o,
    output logic                       rd_error1_o,
    output logic                       rd_error2_o,
    input  logic                       scrub_en_i,
    input  logic                       inj_en_i,
    input  logic [$clog2(DEPTH)-1:0]   inj_addr_i,
    input  logic [1:0]                 inj_copy_i,
    input  logic [DATA_WIDTH-1:0]      inj_mask_i,
    input  logic                       clr_cnt_i,
    output logic [CNT_WIDTH-1:0]       err1_cnt_o,
    output logic [CNT_WIDTH-1:0]       err2_cnt_o,
    output logic                       irq_o,
    output logic                       scrub_busy_o
);

    localparam int                   AW           = $clog2(DEPTH);
    localparam int                   TW           = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [TW-1:0]        TIMER_RELOAD = TW'(SCRUB_PERIOD - 1);
    localparam logic [AW-1:0]        LAST_IDX     = AW'(DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX      = '1;

    logic [DATA_WIDTH-1:0] mem_q [NUM_COPIES][DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [NUM_COPIES][DEPTH];
    scrub_state_e          state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] fix_data_q, fix_data_d;
    logic [CNT_WIDTH-1:0]  err1_cnt_q, err1_cnt_d;
    logic [CNT_WIDTH-1:0]  err2_cnt_q, err2_cnt_d;
    logic                  irq_q, irq_d;

    logic [DATA_WIDTH-1:0] scan_maj;
    logic                  scan_err1;
    logic                  scan_err2;
    logic                  user_hit;
    logic                  inj_hit;
    logic                  advance;
    logic                  wb_en;
    logic                  err1_inc;
    logic                  err2_inc;

    way3_voter #(.DATA_WIDTH(DATA_WIDTH)) u_rd_voter (
        .a_i    (mem_q[COPY_0][rd_addr_i]),
        .b_i    (mem_q[COPY_1][rd_addr_i]),
        .c_i    (mem_q[COPY_2][rd_addr_i]),
        .maj_o  (rd_data_o),
        .err1_o (rd_error1_o),
        .err2_o (rd_error2_o)
    );

    way3_voter #(.DATA_WIDTH(DATA_WIDTH)) u_scan_voter (
        .a_i    (mem_q[COPY_0][idx_q]),
        .b_i    (mem_q[COPY_1][idx_q]),
        .c_i    (mem_q[COPY_2][idx_q]),
        .maj_o  (scan_maj),
        .err1_o (scan_err1),
        .err2_o (scan_err2)
    );

    assign user_hit = wr_en_i && (wr_addr_i == idx_q);
    assign inj_hit  = inj_en_i && (inj_copy_i != COPY_NONE) && !(wr_en_i && (wr_addr_i == inj_addr_i));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        fix_data_d = fix_data_q;
        advance    = 1'b0;
        wb_en      = 1'b0;
        err1_inc   = 1'b0;
        err2_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (scrub_en_i) begin
                    state_d = ST_WAIT;
                    timer_d = TIMER_RELOAD;
                    idx_d   = '0;
                end
            end
            ST_WAIT: begin
                if (!scrub_en_i) begin
                    state_d = ST_IDLE;
                end else if (timer_q == '0) begin
                    state_d = ST_SCAN;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            ST_SCAN: begin
                err1_inc = scan_err1;
                err2_inc = scan_err2;
                if (scan_err1 && !user_hit) begin
                    state_d    = ST_FIX;
                    fix_data_d = scan_maj;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_FIX: begin
                // A write elsewhere holds the fix; a write to idx makes the fix stale.
                if (user_hit) begin
                    advance = 1'b1;
                end else if (!wr_en_i) begin
                    wb_en   = 1'b1;
                    advance = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (advance) begin
            if (!scrub_en_i) begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end else if (idx_q == LAST_IDX) begin
                state_d = ST_WAIT;
                timer_d = TIMER_RELOAD;
                idx_d   = '0;
            end else begin
                state_d = ST_SCAN;
                idx_d   = idx_q + AW'(1);
            end
        end
    end

    // Order matters: user write, then scrub writeback, then injection on top.
    always_comb begin
        mem_d = mem_q;
        for (int c = 0; c < NUM_COPIES; c++) begin
            if (wr_en_i) begin
                mem_d[c][wr_addr_i] = wr_data_i;
            end
            if (wb_en) begin
                mem_d[c][idx_q] = fix_data_q;
            end
            if (inj_hit && (inj_copy_i == 2'(c))) begin
                mem_d[c][inj_addr_i] = mem_d[c][inj_addr_i] ^ inj_mask_i;
            end
        end
    end

    always_comb begin
        err1_cnt_d = err1_cnt_q;
        err2_cnt_d = err2_cnt_q;
        irq_d      = irq_q;
        if (clr_cnt_i) begin
            err1_cnt_d = '0;
            err2_cnt_d = '0;
            irq_d      = 1'b0;
        end else begin
            if (err1_inc && (err1_cnt_q != CNT_MAX)) begin
                err1_cnt_d = err1_cnt_q + CNT_WIDTH'(1);
            end
            if (err2_inc && (err2_cnt_q != CNT_MAX)) begin
                err2_cnt_d = err2_cnt_q + CNT_WIDTH'(1);
            end
            if (err2_inc) begin
                irq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int c = 0; c < NUM_COPIES; c++) begin
                for (int w = 0; w < DEPTH; w++) begin
                    mem_q[c][w] <= '0;
                end
            end
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            timer_q    <= '0;
            fix_data_q <= '0;
            err1_cnt_q <= '0;
            err2_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            fix_data_q <= fix_data_d;
            err1_cnt_q <= err1_cnt_d;
            err2_cnt_q <= err2_cnt_d;
            irq_q      <= irq_d;
        end
    end

    assign err1_cnt_o   = err1_cnt_q;
    assign err2_cnt_o   = err2_cnt_q;
    assign irq_o        = irq_q;
    assign scrub_busy_o = (state_q == ST_SCAN) || (state_q == ST_FIX);

endmodule
`default_nettype wire
